// File: rtl/exe_mem_reg_pkg.sv
// -----------------------------------------------------------------------------
// exe_mem_reg_pkg
// Shared core types for the execute/memory pipeline boundary.
//   flags_t     : architectural status vector {Z,C,N,V}
//   FLAG_*      : bit positions inside flags_t
//   mem_ctrl_t  : memory-stage control bundle {wb_en, mem_r_en, mem_w_en}
//   gate_ctrl() : qualifies a control bundle with its valid bit and resolves
//                 the illegal read+write combination in favour of the read
// -----------------------------------------------------------------------------
package exe_mem_reg_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;
    localparam int FLAG_W = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
    } mem_ctrl_t;

    // A bubble never carries live control; a read+write request degrades to a
    // read so the memory stage never sees both strobes at once.
    function automatic mem_ctrl_t gate_ctrl(input mem_ctrl_t c, input logic v);
        mem_ctrl_t g;
        g.wb_en    = c.wb_en & v;
        g.mem_r_en = c.mem_r_en & v;
        g.mem_w_en = c.mem_w_en & v & ~c.mem_r_en;
        return g;
    endfunction

endpackage

// File: rtl/exe_mem_reg_if.sv
// -----------------------------------------------------------------------------
// exe_mem_reg_if
// Bundle between the execute stage and the exe/mem pipeline register.
//   master : execute side (drives pipeline controls and execute results,
//            observes the memory-stage outputs and status)
//   slave  : the exe_mem_reg block itself
// Signals:
//   freeze, flush, exe_valid, alu_result, sr_in, s_bit, st_val, dest,
//   wb_en, mem_r_en, mem_w_en                         (execute -> register)
//   mem_valid, mem_alu_result, mem_st_val, mem_dest,
//   mem_wb_en, mem_mem_r_en, mem_mem_w_en, status     (register -> memory)
//   fwd_valid, fwd_dest, fwd_value                    (only with FWD_EN)
// -----------------------------------------------------------------------------
interface exe_mem_reg_if;
    import exe_mem_reg_pkg::*;

    logic              freeze;
    logic              flush;
    logic              exe_valid;
    logic [DATA_W-1:0] alu_result;
    flags_t            sr_in;
    logic              s_bit;
    logic [DATA_W-1:0] st_val;
    logic [REG_W-1:0]  dest;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;

    logic              mem_valid;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_st_val;
    logic [REG_W-1:0]  mem_dest;
    logic              mem_wb_en;
    logic              mem_mem_r_en;
    logic              mem_mem_w_en;
    flags_t            status;

`ifdef FWD_EN
    logic              fwd_valid;
    logic [REG_W-1:0]  fwd_dest;
    logic [DATA_W-1:0] fwd_value;
`endif

    modport master (
`ifdef FWD_EN
        input  fwd_valid, fwd_dest, fwd_value,
`endif
        output freeze, flush, exe_valid, alu_result, sr_in, s_bit, st_val,
               dest, wb_en, mem_r_en, mem_w_en,
        input  mem_valid, mem_alu_result, mem_st_val, mem_dest, mem_wb_en,
               mem_mem_r_en, mem_mem_w_en, status
    );

    modport slave (
`ifdef FWD_EN
        output fwd_valid, fwd_dest, fwd_value,
`endif
        input  freeze, flush, exe_valid, alu_result, sr_in, s_bit, st_val,
               dest, wb_en, mem_r_en, mem_w_en,
        output mem_valid, mem_alu_result, mem_st_val, mem_dest, mem_wb_en,
               mem_mem_r_en, mem_mem_w_en, status
    );

endinterface

// File: rtl/exe_mem_reg_status_reg.sv
// -----------------------------------------------------------------------------
// status_reg
// Architectural status register {Z,C,N,V} with a write enable.
//   clk : core clock
//   rst : synchronous active-high reset, clears the flags
//   we  : load d on the next rising edge
//   d   : incoming flags
//   q   : current architectural flags
// -----------------------------------------------------------------------------
module status_reg
    import exe_mem_reg_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  flags_t d,
    output flags_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe_mem_reg.sv
// -----------------------------------------------------------------------------
// exe_mem_reg
// Execute -> memory pipeline boundary of the ARM core. Registers the ALU
// result, store data, destination and memory control, and owns the
// architectural status flags updated by S-suffixed instructions.
// Ports:
//   clk : core clock, rising edge
//   rst : synchronous active-high reset
//   bus : exe_mem_reg_if.slave (see interface file for the signal list)
// Per-edge priority: rst > freeze > flush > normal capture.
// Optional feature macro: FWD_EN adds the fwd_valid/fwd_dest/fwd_value taps
// (ALU results only; load results are never forwarded from here).
// -----------------------------------------------------------------------------
module exe_mem_reg
    import exe_mem_reg_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    exe_mem_reg_if.slave  bus
);

    logic              vld_p1;
    logic [DATA_W-1:0] alu_result_p1;
    logic [DATA_W-1:0] st_val_p1;
    logic [REG_W-1:0]  dest_p1;
    mem_ctrl_t         ctrl_p1;
    mem_ctrl_t         ctrl_p0;
    logic              status_we_p0;

    assign ctrl_p0 = '{wb_en:    bus.wb_en,
                       mem_r_en: bus.mem_r_en,
                       mem_w_en: bus.mem_w_en};

    // Flags retire only with a real, unstalled, unflushed S instruction.
    assign status_we_p0 = bus.exe_valid & bus.s_bit & ~bus.freeze & ~bus.flush;

    // ---- execute -> memory stage boundary ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            ctrl_p1       <= '0;
            alu_result_p1 <= '0;
            st_val_p1     <= '0;
            dest_p1       <= '0;
        end else if (!bus.freeze) begin
            vld_p1        <= bus.exe_valid & ~bus.flush;
            ctrl_p1       <= gate_ctrl(ctrl_p0, bus.exe_valid & ~bus.flush);
            // Data is don't-care under a bubble, so it is captured regardless.
            alu_result_p1 <= bus.alu_result;
            st_val_p1     <= bus.st_val;
            dest_p1       <= bus.dest;
        end
    end

    status_reg u_status_reg (
        .clk (clk),
        .rst (rst),
        .we  (status_we_p0),
        .d   (bus.sr_in),
        .q   (bus.status)
    );

    assign bus.mem_valid      = vld_p1;
    assign bus.mem_alu_result = alu_result_p1;
    assign bus.mem_st_val     = st_val_p1;
    assign bus.mem_dest       = dest_p1;
    assign bus.mem_wb_en      = ctrl_p1.wb_en;
    assign bus.mem_mem_r_en   = ctrl_p1.mem_r_en;
    assign bus.mem_mem_w_en   = ctrl_p1.mem_w_en;

`ifdef FWD_EN
    assign bus.fwd_valid = vld_p1 & ctrl_p1.wb_en & ~ctrl_p1.mem_r_en;
    assign bus.fwd_dest  = dest_p1;
    assign bus.fwd_value = alu_result_p1;
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// -----------------------------------------------------------------------------
// tb_exe_mem_reg
// Directed bench for exe_mem_reg. Each step drives one cycle of execute-side
// inputs, pushes the expected memory-stage state onto a scoreboard queue,
// and pops/compares it one edge later. Build with +define+FWD_EN to also
// cover the forwarding taps.
// -----------------------------------------------------------------------------
module tb_exe_mem_reg;
    import exe_mem_reg_pkg::*;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] st;
        logic [3:0]  dest;
        logic        wb;
        logic        rd;
        logic        wr;
        logic [3:0]  status;
        logic        data_known;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exe_mem_reg_if bus ();

    exe_mem_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb_q[$];
    exp_t m;   // reference state of the memory-stage register

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic fz, input logic fl, input logic ev,
                        input logic [31:0] alu, input logic [31:0] st,
                        input logic [3:0] sr, input logic s, input logic [3:0] d,
                        input logic wb, input logic rd, input logic wr);
        exp_t e;
        rst            = r;
        bus.freeze     = fz;
        bus.flush      = fl;
        bus.exe_valid  = ev;
        bus.alu_result = alu;
        bus.st_val     = st;
        bus.sr_in      = sr;
        bus.s_bit      = s;
        bus.dest       = d;
        bus.wb_en      = wb;
        bus.mem_r_en   = rd;
        bus.mem_w_en   = wr;

        if (r) begin
            m = '{valid: 1'b0, alu: 32'h0, st: 32'h0, dest: 4'h0, wb: 1'b0,
                  rd: 1'b0, wr: 1'b0, status: 4'h0, data_known: 1'b1};
        end else if (fz) begin
            m = m;
        end else if (fl) begin
            m.valid = 1'b0;
            m.wb = 1'b0;
            m.rd = 1'b0;
            m.wr = 1'b0;
            m.data_known = 1'b0;
        end else begin
            m.valid = ev;
            m.alu   = alu;
            m.st    = st;
            m.dest  = d;
            m.wb    = wb & ev;
            m.rd    = rd & ev;
            m.wr    = wr & ev & !rd;
            m.data_known = 1'b1;
            if (ev && s) m.status = sr;
        end
        sb_q.push_back(m);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("mem_valid", {31'b0, bus.mem_valid}, {31'b0, e.valid});
        chk("mem_wb_en", {31'b0, bus.mem_wb_en}, {31'b0, e.wb});
        chk("mem_mem_r_en", {31'b0, bus.mem_mem_r_en}, {31'b0, e.rd});
        chk("mem_mem_w_en", {31'b0, bus.mem_mem_w_en}, {31'b0, e.wr});
        chk("status", {28'b0, bus.status}, {28'b0, e.status});
        if (e.data_known) begin
            chk("mem_alu_result", bus.mem_alu_result, e.alu);
            chk("mem_st_val", bus.mem_st_val, e.st);
            chk("mem_dest", {28'b0, bus.mem_dest}, {28'b0, e.dest});
        end
`ifdef FWD_EN
        chk("fwd_valid", {31'b0, bus.fwd_valid}, {31'b0, e.valid & e.wb & !e.rd});
        if (e.data_known) begin
            chk("fwd_dest", {28'b0, bus.fwd_dest}, {28'b0, e.dest});
            chk("fwd_value", bus.fwd_value, e.alu);
        end
`endif
    endtask

    initial begin
        m = '{valid: 1'b0, alu: 32'h0, st: 32'h0, dest: 4'h0, wb: 1'b0,
              rd: 1'b0, wr: 1'b0, status: 4'h0, data_known: 1'b1};

        // Reset for two cycles with random inputs.
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        chk("reset_status", {28'b0, bus.status}, 32'h0);
        chk("reset_valid", {31'b0, bus.mem_valid}, 32'h0);

        // Plain ALU op right after reset.
        step(0, 0, 0, 1, 32'h0000_0010, 32'hCAFE_0001, 4'h0, 0, 4'd5, 1, 0, 0);
        chk("first_alu", bus.mem_alu_result, 32'h10);
        chk("first_dest", {28'b0, bus.mem_dest}, 32'd5);
`ifdef FWD_EN
        chk("first_fwd_valid", {31'b0, bus.fwd_valid}, 32'd1);
        chk("first_fwd_value", bus.fwd_value, 32'h10);
`endif

        // Flag-setting instruction, then a non-S one.
        step(0, 0, 0, 1, 32'h1111_0000, 32'h0, 4'b1010, 1, 4'd1, 1, 0, 0);
        chk("status_set", {28'b0, bus.status}, 32'b1010);
        step(0, 0, 0, 1, 32'h2222_0000, 32'h0, 4'b0101, 0, 4'd2, 1, 0, 0);
        chk("status_kept", {28'b0, bus.status}, 32'b1010);

        // Three frozen cycles with changing inputs, including S and flush.
        step(0, 1, 0, 1, 32'hDEAD_0001, 32'h1, 4'b1111, 1, 4'd7, 0, 1, 0);
        step(0, 1, 1, 1, 32'hDEAD_0002, 32'h2, 4'b0001, 1, 4'd8, 1, 0, 1);
        step(0, 1, 0, 0, 32'hDEAD_0003, 32'h3, 4'b0011, 1, 4'd9, 0, 0, 1);
        chk("freeze_alu", bus.mem_alu_result, 32'h2222_0000);
        chk("freeze_status", {28'b0, bus.status}, 32'b1010);

        // Release.
        step(0, 0, 0, 1, 32'h0000_0020, 32'h55, 4'h0, 0, 4'd4, 1, 0, 0);
        chk("release_alu", bus.mem_alu_result, 32'h20);

        // Flush with S and store; then flush together with freeze.
        step(0, 0, 1, 1, 32'h3333_0000, 32'h77, 4'b0100, 1, 4'd6, 0, 0, 1);
        chk("flush_valid", {31'b0, bus.mem_valid}, 32'd0);
        chk("flush_status", {28'b0, bus.status}, 32'b1010);
        step(0, 0, 0, 1, 32'h4444_0000, 32'h88, 4'h0, 0, 4'd10, 1, 0, 0);
        step(0, 1, 1, 1, 32'h5555_0000, 32'h99, 4'b0100, 1, 4'd11, 0, 0, 1);
        chk("flush_freeze_valid", {31'b0, bus.mem_valid}, 32'd1);

        // Load: not forwardable; then illegal read+write.
        step(0, 0, 0, 1, 32'h0000_1000, 32'h0, 4'h0, 0, 4'd3, 1, 1, 0);
        chk("load_r_en", {31'b0, bus.mem_mem_r_en}, 32'd1);
        step(0, 0, 0, 1, 32'h0000_2000, 32'hABCD, 4'h0, 0, 4'd3, 0, 1, 1);
        chk("rw_w_en", {31'b0, bus.mem_mem_w_en}, 32'd0);
        chk("rw_r_en", {31'b0, bus.mem_mem_r_en}, 32'd1);

        // Invalid instruction gates control and blocks status.
        step(0, 0, 0, 0, 32'h6666_0000, 32'h1, 4'b0001, 1, 4'd12, 1, 1, 1);
        step(0, 0, 0, 1, 32'h7777_0000, 32'h2, 4'b0011, 1, 4'd13, 1, 0, 1);

        // Held instruction discarded by reset during a stall.
        step(0, 1, 0, 1, 32'h8888_0000, 32'h3, 4'b1100, 1, 4'd14, 0, 1, 0);
        step(1, 1, 0, 1, 32'h9999_0000, 32'h4, 4'b1100, 1, 4'd15, 1, 1, 1);
        chk("reset_in_stall_status", {28'b0, bus.status}, 32'h0);

        // Random traffic.
        for (int i = 0; i < 24; i++)
            step(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom),
                 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/exe_mem_reg.md
# exe_mem_reg

Pipeline boundary between the execute and memory stages of the ARM core. Captures the ALU result, store data, and control for the memory stage. Owns the architectural status register {Z,C,N,V}, which it updates from ALU flags when an S-suffixed instruction retires out of execute. Supports freeze (memory stall) and flush (branch taken) semantics.

## Interface
- No parameters; widths are fixed by the ISA (32-bit data, 4-bit register index, 4-bit flags).
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- freeze  in  1  hold every register (memory-stage stall)
- flush  in  1  replace incoming instruction with a bubble
- exe_valid  in  1  execute stage holds a real instruction
- alu_result  in  32  ALU output
- sr_in  in  4  ALU flags {z,c,n,v}
- s_bit  in  1  instruction updates status
- st_val  in  32  store data (Rd value for STR)
- dest  in  4  destination register index
- wb_en, mem_r_en, mem_w_en  in  1 each  control from decode
- mem_valid  out  1  memory stage holds a real instruction
- mem_alu_result  out  32  registered alu_result (address for LDR/STR)
- mem_st_val  out  32  registered st_val
- mem_dest  out  4  registered dest
- mem_wb_en, mem_mem_r_en, mem_mem_w_en  out  1 each  registered control, forced 0 when not valid
- status  out  4  architectural {z,c,n,v}; feeds ALU sr_in and decode condition check
- fwd_valid, fwd_dest (4), fwd_value (32)  out  forwarding taps; present only under FWD_EN

## Operation
- Priority per edge: rst > freeze > flush > normal capture.
- rst: every output register cleared to 0, including status = 4'b0000.
- freeze: all registers hold, including status. flush is ignored while freeze is asserted; upstream keeps flush high until freeze drops.
- flush (no freeze): mem_valid ← 0; all mem_* control ← 0. Data registers may hold don't-care values. Status is not updated.
- Normal: mem_valid ← exe_valid. Data and dest are captured unconditionally. Control bits are captured ANDed with exe_valid.
- Status update: status ← sr_in only when exe_valid & s_bit & !freeze & !flush & !rst. Otherwise status holds.
- Illegal mem_r_en & mem_w_en both 1: capture mem_mem_r_en=1, mem_mem_w_en=0.
- No arithmetic is performed; widths pass through unchanged.

## Timing
- Latency: 1 cycle, execute inputs to mem_* outputs.
- Status is visible to the next instruction in execute on the cycle after the flag-setting instruction captures. There is no same-cycle bypass.
- All outputs come directly from flops except the fwd_* ports, which are combinational from flops.
- Simultaneous rst and freeze: reset wins.
- Reset asserted mid-stall: the held instruction is discarded.

## Configuration
- FWD_EN defined:
  - fwd_valid = mem_valid & mem_wb_en & !mem_mem_r_en
  - fwd_dest = mem_dest
  - fwd_value = mem_alu_result
  - Load results are never forwarded from this stage.
- FWD_EN undefined: the fwd_* ports and their logic are absent. The hazard unit must stall instead.

## Structure
- Shared core package holds:
  - the flag-vector typedef and bit-position constants (Z=3, C=2, N=1, V=0)
  - the memory-control bundle typedef {wb_en, mem_r_en, mem_w_en}
- One sub-module: status_reg. It is a 4-bit register with a write enable, holding the architectural flags. Everything else stays flat.

## Test plan
- rst high for 2 cycles with random inputs → all outputs 0 and status=0000. The first edge after rst drops captures normally.
- exe_valid=1, alu_result=0x0000_0010, dest=5, wb_en=1 → next cycle mem_alu_result=0x10, mem_dest=5, mem_wb_en=1, mem_valid=1. Under FWD_EN, fwd_valid=1 and fwd_value=0x10.
- s_bit=1, sr_in=1010, exe_valid=1 → status=1010 next cycle. The following instruction with s_bit=0, sr_in=0101 leaves status=1010.
- freeze=1 for 3 cycles with changing inputs → mem_* outputs and status stay constant. Release with new alu_result=0x20 → captured 1 cycle later.
- flush=1 with s_bit=1, sr_in=0100, mem_w_en=1 → mem_valid=0, mem_mem_w_en=0, status unchanged. flush=1 together with freeze=1 → state held.
- mem_r_en=1, wb_en=1, dest=3 → mem_mem_r_en=1. Under FWD_EN, fwd_valid=0. With mem_r_en and mem_w_en both 1 → mem_mem_w_en=0.
